// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches single-cycle strobes into pulses with minimum high/low width and a bounded event queue
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 1000000,
  parameter int GAP_CYCLES  = 1000000,
  parameter int PEND_MAX    = 3
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              trig_i,
  output logic                              pulse_o,
  output logic                              busy_o,
  output logic [$clog2(PEND_MAX+1)-1:0]     pending_o,
  output logic                              drop_o
);

  localparam int MAX_C = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam int PW    = $clog2(PEND_MAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            drop_d;
  logic            hold_end, gap_end, can_queue;

  assign hold_end  = (cnt_q == CW'(HOLD_CYCLES - 1));
  assign gap_end   = (cnt_q == CW'(GAP_CYCLES - 1));
  assign can_queue = (pend_q < PW'(PEND_MAX));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_i) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (hold_end) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (trig_i) begin
          if (can_queue) pend_d = pend_q + 1'b1;
          else           drop_d = 1'b1;
        end
      end
      GAP: begin
        if (gap_end) begin
          // A trig on the consuming cycle cancels the dequeue, so the count never overflows here.
          if (pend_q != '0 || trig_i) begin
            state_d = HOLD;
            cnt_d   = '0;
            if (pend_q != '0 && !trig_i) pend_d = pend_q - 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (trig_i) begin
            if (can_queue) pend_d = pend_q + 1'b1;
            else           drop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      drop_o    <= 1'b0;
      pulse_o   <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      drop_o    <= drop_d;
      pulse_o   <= (state_d == HOLD);
      busy_o    <= (state_d != IDLE);
    end
  end

  assign pending_o = pend_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed spec scenarios plus randomized run against a timeline-based reference model
module tb_pulse_stretcher;

  localparam int H = 4;
  localparam int G = 2;
  localparam int P = 2;
  localparam int PW = $clog2(P + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          trig_i = 1'b0;
  logic          pulse_o, busy_o, drop_o;
  logic [PW-1:0] pending_o;

  int errs = 0;
  int checks = 0;

  // Reference model: a pulse accepted at edge s owns edges s+1 .. s+H+G, its final edge may start the next.
  int edge_n = 0;
  int last_e = 0;
  int start_e = 0;
  int pend_m = 0;
  bit have_m = 0;
  bit drop_m = 0;

  pulse_stretcher #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .PEND_MAX(P)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .trig_i(trig_i),
    .pulse_o(pulse_o), .busy_o(busy_o), .pending_o(pending_o), .drop_o(drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    have_m = 0;
    pend_m = 0;
    drop_m = 0;
  endtask

  task automatic model_edge(input logic t, input int e);
    drop_m = 0;
    if (!have_m) begin
      if (t) begin
        have_m = 1;
        start_e = e;
      end
    end else if (e == start_e + H + G) begin
      if (pend_m > 0 || t) begin
        if (pend_m > 0 && !t) pend_m = pend_m - 1;
        start_e = e;
      end else begin
        have_m = 0;
      end
    end else if (t) begin
      if (pend_m < P) pend_m = pend_m + 1;
      else drop_m = 1;
    end
  endtask

  function automatic logic exp_pulse();
    return have_m && (last_e - start_e) < H;
  endfunction

  // Drive one edge's inputs, let the edge happen, then settle 1 time unit after it.
  task automatic tick(input logic t, input logic r);
    rst_i  = r;
    trig_i = t;
    @(posedge clk_i);
    #1;
    last_e = edge_n;
    edge_n = edge_n + 1;
    if (r) model_reset();
    else model_edge(t, last_e);
    trig_i = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if ({pulse_o, busy_o, pending_o, drop_o} !== '0) begin
      errs++;
      $display("FAIL reset_async got p=%b b=%b n=%0d d=%b want all 0", pulse_o, busy_o, pending_o, drop_o);
    end
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    checks++;
    if ({pulse_o, busy_o, pending_o, drop_o} !== '0) begin
      errs++;
      $display("FAIL reset_clocked got p=%b b=%b n=%0d d=%b want all 0", pulse_o, busy_o, pending_o, drop_o);
    end
  endtask

  task automatic test_single();
    logic [8:1] pe = 8'h0F;
    logic [8:1] be = 8'h3F;
    for (int c = 1; c <= 8; c++) begin
      tick(c == 1, 1'b0);
      checks++;
      if (pulse_o !== pe[c] || busy_o !== be[c] || pending_o !== '0 || drop_o !== 1'b0) begin
        errs++;
        $display("FAIL single c=%0d got p=%b b=%b n=%0d d=%b want p=%b b=%b n=0 d=0",
                 c, pulse_o, busy_o, pending_o, drop_o, pe[c], be[c]);
      end
    end
  endtask

  task automatic test_queue_overflow();
    logic [20:1] pe = 20'b0000_1111_00_1111_00_1111;
    logic [20:1] be = 20'h3FFFF;
    logic [20:1] de = 20'h00008;
    int np;
    for (int c = 1; c <= 20; c++) begin
      tick(c <= 4, 1'b0);
      np = (c < 2) ? 0 : (c == 2) ? 1 : (c < 7) ? 2 : (c < 13) ? 1 : 0;
      checks++;
      if (pulse_o !== pe[c] || busy_o !== be[c] || pending_o !== PW'(np) || drop_o !== de[c]) begin
        errs++;
        $display("FAIL queue_overflow c=%0d got p=%b b=%b n=%0d d=%b want p=%b b=%b n=%0d d=%b",
                 c, pulse_o, busy_o, pending_o, drop_o, pe[c], be[c], np, de[c]);
      end
    end
  endtask

  task automatic test_gap_trig();
    logic [13:1] pe = 13'b000_1111_00_1111;
    logic [13:1] be = 13'h0FFF;
    for (int c = 1; c <= 13; c++) begin
      tick(c == 1 || c == 7, 1'b0);
      checks++;
      if (pulse_o !== pe[c] || busy_o !== be[c] || pending_o !== '0 || drop_o !== 1'b0) begin
        errs++;
        $display("FAIL gap_trig c=%0d got p=%b b=%b n=%0d d=%b want p=%b b=%b n=0 d=0",
                 c, pulse_o, busy_o, pending_o, drop_o, pe[c], be[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [20:1] pe = 20'b0000_1111_00_1111_00_1111;
    logic [20:1] be = 20'h3FFFF;
    int np;
    for (int c = 1; c <= 20; c++) begin
      tick(c == 1 || c == 3 || c == 7, 1'b0);
      np = (c >= 3 && c <= 12) ? 1 : 0;
      checks++;
      if (pulse_o !== pe[c] || busy_o !== be[c] || pending_o !== PW'(np) || drop_o !== 1'b0) begin
        errs++;
        $display("FAIL back_to_back c=%0d got p=%b b=%b n=%0d d=%b want p=%b b=%b n=%0d d=0",
                 c, pulse_o, busy_o, pending_o, drop_o, pe[c], be[c], np);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [8:1] pe = 8'h0F;
    logic [8:1] be = 8'h3F;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (pulse_o !== 1'b1 || pending_o !== PW'(1)) begin
      errs++;
      $display("FAIL mid_pulse_pre got p=%b n=%0d want p=1 n=1", pulse_o, pending_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({pulse_o, busy_o, pending_o, drop_o} !== '0) begin
      errs++;
      $display("FAIL mid_pulse_async got p=%b b=%b n=%0d d=%b want all 0", pulse_o, busy_o, pending_o, drop_o);
    end
    tick(1'b0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      tick(c == 1, 1'b0);
      checks++;
      if (pulse_o !== pe[c] || busy_o !== be[c] || pending_o !== '0 || drop_o !== 1'b0) begin
        errs++;
        $display("FAIL mid_pulse_after c=%0d got p=%b b=%b n=%0d d=%b want p=%b b=%b n=0 d=0",
                 c, pulse_o, busy_o, pending_o, drop_o, pe[c], be[c]);
      end
    end
  endtask

  task automatic test_random();
    int prob;
    logic t, r;
    for (int i = 0; i < 800; i++) begin
      prob = ((i / 100) % 2 == 1) ? 75 : 20;
      r = ($urandom_range(0, 149) == 0);
      t = ($urandom_range(0, 99) < prob);
      tick(t, r);
      checks++;
      if (pulse_o !== exp_pulse() || busy_o !== have_m || pending_o !== PW'(pend_m) || drop_o !== drop_m) begin
        errs++;
        $display("FAIL random i=%0d got p=%b b=%b n=%0d d=%b want p=%b b=%b n=%0d d=%b",
                 i, pulse_o, busy_o, pending_o, drop_o, exp_pulse(), have_m, pend_m, drop_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue_overflow();
    test_gap_trig();
    test_back_to_back();
    test_reset_mid_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Output-side counterpart to the button debouncer: it turns single-cycle event strobes into clean, human-visible pulses of guaranteed minimum high and low width. It drives LEDs, indicator pins or slow downstream logic in the fibonacci_2 design. Strobes that arrive while a pulse is in progress are queued up to a bound. Overflow is flagged rather than silently lost.

## Interface
- HOLD_CYCLES, 1000000: clock cycles `pulse_o` stays high per event; must be ≥1.
- GAP_CYCLES, 1000000: minimum clock cycles `pulse_o` stays low between consecutive pulses; must be ≥1.
- PEND_MAX, 3: maximum number of queued events; must be ≥1.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- trig_i  input  1  event strobe; every cycle sampled high is one event.
- pulse_o  output  1  stretched pulse; registered.
- busy_o  output  1  high whenever the state is not IDLE; registered.
- pending_o  output  $clog2(PEND_MAX+1)  number of queued events; registered.
- drop_o  output  1  one-cycle flag: an event was discarded because the queue was full; registered.

## Operation
- Registers:
  - state: IDLE, HOLD, GAP.
  - cycle counter: width $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1).
  - pending count.
  - drop flag.
- Output decode:
  - `pulse_o` = (state == HOLD).
  - `busy_o` = (state != IDLE).
  - `pending_o` = pending count.
- IDLE:
  - trig_i=1 → HOLD, counter←0.
  - Otherwise stay in IDLE.
  - Invariant: pending is 0 in IDLE.
- HOLD:
  - counter increments each cycle.
  - At counter==HOLD_CYCLES-1 → GAP, counter←0.
- GAP:
  - counter increments each cycle.
  - At counter==GAP_CYCLES-1:
    - if pending>0 or trig_i=1 → HOLD, counter←0, one event consumed;
    - otherwise → IDLE.
  - No idle cycle is inserted between GAP and the next HOLD.
- Queueing, in HOLD and GAP except on the consuming GAP-end cycle:
  - trig_i=1 with pending<PEND_MAX → pending+1.
  - trig_i=1 with pending==PEND_MAX → pending unchanged, drop flag←1 for one cycle.
- Consuming GAP-end cycle:
  - The consumed event is the oldest queued one.
  - If pending>0 and trig_i=1 simultaneously: pending unchanged (−1 consume, +1 enqueue); no drop.
  - If pending==0 and trig_i=1: the trig itself is consumed; pending stays 0.
- drop flag is cleared to 0 on every cycle without an overflow.
- Pending arithmetic:
  - saturates at PEND_MAX;
  - never underflows, since a consume occurs only when pending>0 or a trig is present.
- Reset (asserted at any time, including mid-HOLD/GAP):
  - state←IDLE, counter←0, pending←0, drop←0, immediately and asynchronously.
  - `pulse_o`, `busy_o`, `pending_o`, `drop_o` all read 0.
  - Queued events are discarded.
  - A trig sampled on the first edge after deassertion is accepted normally.

## Timing
- Trig sampled at edge N from IDLE:
  - `pulse_o` high for cycles N+1 … N+HOLD_CYCLES;
  - low for GAP_CYCLES cycles;
  - `busy_o` high for HOLD_CYCLES+GAP_CYCLES cycles.
- Back-to-back queued pulses: period is exactly HOLD_CYCLES+GAP_CYCLES cycles.
- `pending_o` updates on the edge after the enqueuing trig.
- `drop_o` is high the cycle after the discarded trig, for exactly one cycle per discarded event. Consecutive drops give consecutive high cycles.
- Earliest next pulse after any pulse: HOLD_CYCLES+GAP_CYCLES cycles after that pulse's start.
- `pulse_o` high width is never shorter than HOLD_CYCLES; low width between pulses is never shorter than GAP_CYCLES. The only exception is reset.

## Test plan
All scenarios use HOLD_CYCLES=4, GAP_CYCLES=2, PEND_MAX=2.
- Reset values: assert rst_i, with and without clock → `pulse_o`=0, `busy_o`=0, `pending_o`=0, `drop_o`=0.
- Single event: trig_i=1 at edge 0 only → `pulse_o` high cycles 1–4, low 5–6; `busy_o` high cycles 1–6, 0 from cycle 7; `pending_o` stays 0.
- Queue and overflow: trig at edge 0, then trig at edges 1, 2, 3 (all in HOLD):
  - `pending_o`=1 at cycle 2, =2 at cycle 3;
  - `drop_o`=1 at cycle 4 only;
  - pulses at cycles 1–4, 7–10, 13–16;
  - `pending_o` decrements at cycles 7 and 13;
  - idle at cycle 19.
- Trig on final GAP cycle with empty queue: trig at edge 0 and edge 6 → pulses at cycles 1–4 and 7–10; `busy_o` never drops between them.
- Simultaneous enqueue and consume: trig at edge 0, edge 2 and edge 6 → `pending_o` =1 from cycle 3 through cycle 12, no `drop_o`; pulses at cycles 1–4, 7–10, 13–16.
- Reset mid-pulse: trig at edge 0 and edge 1, assert rst_i during cycle 2 → `pulse_o`, `busy_o` and `pending_o` go to 0 immediately. After release, a new trig yields a full 4-cycle pulse with no residual queued pulse.
